// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage sitting directly after the PC register. The current
// PC is issued to instruction memory over a request/grant interface; PCWre
// pulses once per accepted request so the PC advances exactly once per grant.
// In-order memory responses are matched to their PCs in a DEPTH-entry
// circular buffer and presented to decode as {pc, instruction} pairs.
// A flush (branch redirect) empties the buffer and arranges for responses
// that are still in flight to be discarded when they arrive.
//
// Handshakes:
//   memory request : a request is accepted on a cycle where imem_req and
//                    imem_gnt are both high; imem_addr is valid with imem_req.
//   memory response: imem_rvalid marks one response, returned in grant order,
//                    no earlier than the cycle after its grant.
//   decode         : a transfer happens on a cycle where id_valid and
//                    id_ready are both high; id_pc/id_inst are stable while
//                    id_valid is high and id_ready is low.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-low reset
//   CurPC        current PC from the PC register
//   PCWre        PC write enable (advance on grant, redirect on flush)
//   imem_req     fetch request to instruction memory
//   imem_addr    fetch address (always CurPC)
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  response valid
//   imem_rdata   response instruction word
//   flush        redirect: discard buffered and in-flight fetches
//   id_valid     instruction available to decode
//   id_ready     decode accepts
//   id_pc        PC of the head entry
//   id_inst      instruction of the head entry
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] CurPC,
    output logic        PCWre,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);

    localparam int AW = $clog2(DEPTH);
    // One extra wrap bit so that full (count == DEPTH) and empty differ.
    localparam int PW = AW + 1;

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [DEPTH-1:0] filled_q;

    logic [PW-1:0] alloc_ptr;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] drop_q;

    logic [PW-1:0] count;
    logic [PW-1:0] unfilled;
    logic [PW-1:0] drop_flush;

    logic [AW-1:0] alloc_idx;
    logic [AW-1:0] fill_idx;
    logic [AW-1:0] head_idx;

    logic grant;
    logic resp_keep;
    logic resp_drop;
    logic pop;

    assign alloc_idx = alloc_ptr[AW-1:0];
    assign fill_idx  = fill_ptr[AW-1:0];
    assign head_idx  = head_ptr[AW-1:0];

    assign count    = alloc_ptr - head_ptr;
    assign unfilled = alloc_ptr - fill_ptr;

    // Requests are held off while stale responses are still expected, so a
    // response can always be attributed either to the drop count or to the
    // fill pointer, never to both.
    assign imem_req  = rst & ~flush & (drop_q == '0) & (count < PW'(DEPTH));
    assign imem_addr = CurPC;
    assign grant     = imem_req & imem_gnt;
    assign PCWre     = grant | (rst & flush);

    assign resp_drop = imem_rvalid & (drop_q != '0);
    assign resp_keep = imem_rvalid & (drop_q == '0);

    assign id_valid = rst & ~flush & filled_q[head_idx];
    assign id_pc    = pc_q[head_idx];
    assign id_inst  = inst_q[head_idx];
    assign pop      = id_valid & id_ready;

    // Every allocated-but-unfilled entry will still be answered by memory and
    // must be thrown away. A response arriving in the flush cycle itself is
    // either a dropped one (drop_q > 0) or fills one of the unfilled entries;
    // in both cases it settles one outstanding response now. drop_q > 0
    // implies no unfilled entries, so the sum never exceeds DEPTH.
    assign drop_flush = drop_q + unfilled - PW'(imem_rvalid);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
            filled_q <= '0;
            if (!rst) begin
                alloc_ptr <= '0;
                fill_ptr  <= '0;
                head_ptr  <= '0;
                drop_q    <= '0;
            end else begin
                fill_ptr <= alloc_ptr;
                head_ptr <= alloc_ptr;
                drop_q   <= drop_flush;
            end
        end else begin
            // Pop, grant and response always target distinct slots: the head
            // is filled, the fill slot is not, and a grant only reuses the
            // head slot when the buffer is empty (no pop possible).
            if (pop) begin
                pc_q[head_idx]     <= '0;
                inst_q[head_idx]   <= '0;
                filled_q[head_idx] <= 1'b0;
                head_ptr           <= head_ptr + PW'(1);
            end
            if (grant) begin
                pc_q[alloc_idx]     <= CurPC;
                filled_q[alloc_idx] <= 1'b0;
                alloc_ptr           <= alloc_ptr + PW'(1);
            end
            if (resp_keep) begin
                inst_q[fill_idx]   <= imem_rdata;
                filled_q[fill_idx] <= 1'b1;
                fill_ptr           <= fill_ptr + PW'(1);
            end
            if (resp_drop) begin
                drop_q <= drop_q - PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//
// Bench for inst_fetch. A behavioural PC register and an in-order memory with
// configurable latency surround the DUT. Every granted fetch pushes its
// expected {pc, inst} onto exp_q; every decode transfer pops and compares.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

    localparam logic [31:0] PAT = 32'hA5A5A5A5;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic        clk;
    logic        rst;
    logic [31:0] CurPC;
    logic        PCWre;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    inst_fetch #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .CurPC       (CurPC),
        .PCWre       (PCWre),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_inst     (id_inst)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- environment state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] cur_pc = '0;
    logic [31:0] redirect = '0;
    mreq_t       mem_q[$];
    logic [63:0] exp_q[$];

    // values sampled one settle-delay into each cycle
    logic        s_req, s_pcwre, s_valid, s_fire;
    logic [31:0] s_addr, s_pc, s_inst;

    // ---------------- driver ----------------
    // One clock cycle: present memory response and PC, sample outputs, take
    // the edge, then update the memory model, PC register and scoreboard.
    task automatic step();
        mreq_t m;
        if (rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0].addr ^ PAT;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        CurPC = cur_pc;
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_pcwre = PCWre;
        s_valid = id_valid;
        s_pc    = id_pc;
        s_inst  = id_inst;
        s_fire  = id_valid & id_ready;
        @(posedge clk);
        cyc++;
        if (imem_rvalid) void'(mem_q.pop_front());
        if (!rst) begin
            mem_q.delete();
            exp_q.delete();
        end else begin
            if (flush) exp_q.delete();
            if (s_req && imem_gnt) begin
                m.addr = s_addr;
                m.due  = cyc + lat - 1;
                mem_q.push_back(m);
                exp_q.push_back({s_addr, s_addr ^ PAT});
            end
            if (s_pcwre) cur_pc = flush ? redirect : cur_pc + 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic [31:0] pc);
        rst    = 1'b0;
        flush  = 1'b0;
        cur_pc = pc;
        step();
        step();
        rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; imem_gnt = 1'b1; id_ready = 1'b0; lat = 1;
        cur_pc = 32'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({s_req, s_pcwre, s_valid} !== 3'b000) begin
                n_errors++;
                $display("FAIL reset_outputs: got req/pcwre/valid=%b, expected 000", {s_req, s_pcwre, s_valid});
            end
            if (i >= 1) begin
                n_checks++;
                if ({s_pc, s_inst} !== 64'h0) begin
                    n_errors++;
                    $display("FAIL reset_head: got %h, expected 0", {s_pc, s_inst});
                end
            end
        end
        rst = 1'b1; imem_gnt = 1'b0;
        step();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h40) begin
            n_errors++;
            $display("FAIL reset_release: got req=%b addr=%h, expected req=1 addr=00000040", s_req, s_addr);
        end
    endtask

    task automatic test_streaming();
        int fires = 0;
        logic [63:0] e;
        lat = 1; imem_gnt = 1'b1; id_ready = 1'b1;
        apply_reset(32'h0);
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (s_req !== 1'b1 || s_pcwre !== 1'b1) begin
                n_errors++;
                $display("FAIL stream_req: got req=%b pcwre=%b, expected 1/1", s_req, s_pcwre);
            end
            n_checks++;
            if (s_fire !== (i >= 2)) begin
                n_errors++;
                $display("FAIL stream_rate cycle %0d: got fire=%b, expected %b", i, s_fire, (i >= 2));
            end
            if (s_fire) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
                n_checks++;
                if ({s_pc, s_inst} !== e || s_pc !== 32'(fires * 4)) begin
                    n_errors++;
                    $display("FAIL stream_data: got %h, expected %h", {s_pc, s_inst}, e);
                end
                fires++;
            end
        end
        n_checks++;
        if (cur_pc !== 32'd80) begin
            n_errors++;
            $display("FAIL stream_pc: got %h, expected 00000050", cur_pc);
        end
    endtask

    task automatic test_backpressure();
        int   fires = 0;
        logic seen = 1'b0;
        logic [63:0] e;
        lat = 1; imem_gnt = 1'b1; id_ready = 1'b0;
        apply_reset(32'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (s_req !== (i < 4)) begin
                n_errors++;
                $display("FAIL bp_req cycle %0d: got %b, expected %b", i, s_req, (i < 4));
            end
            if (i >= 4) begin
                n_checks++;
                if (s_valid !== 1'b1 || s_pc !== 32'h0) begin
                    n_errors++;
                    $display("FAIL bp_hold: got valid=%b pc=%h, expected 1/00000000", s_valid, s_pc);
                end
            end
        end
        n_checks++;
        if (cur_pc !== 32'd16) begin
            n_errors++;
            $display("FAIL bp_pc: got %h, expected 00000010", cur_pc);
        end
        id_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (s_req && !seen) begin
                seen = 1'b1;
                n_checks++;
                if (s_addr !== 32'd16) begin
                    n_errors++;
                    $display("FAIL bp_resume: got addr=%h, expected 00000010", s_addr);
                end
            end
            if (s_fire) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
                n_checks++;
                if ({s_pc, s_inst} !== e || s_pc !== 32'(fires * 4)) begin
                    n_errors++;
                    $display("FAIL bp_data: got %h, expected %h", {s_pc, s_inst}, e);
                end
                fires++;
            end
        end
        n_checks++;
        if (fires < 8 || !seen) begin
            n_errors++;
            $display("FAIL bp_drain: got %0d transfers resumed=%b, expected >=8 and 1", fires, seen);
        end
    endtask

    task automatic test_grant_stall();
        logic got = 1'b0;
        logic [63:0] e;
        lat = 1; imem_gnt = 1'b0; id_ready = 1'b1;
        apply_reset(32'h200);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({s_req, s_pcwre, s_valid} !== 3'b100 || s_addr !== 32'h200) begin
                n_errors++;
                $display("FAIL stall: got req/pcwre/valid=%b addr=%h, expected 100 00000200",
                         {s_req, s_pcwre, s_valid}, s_addr);
            end
        end
        imem_gnt = 1'b1;
        for (int i = 0; i < 6 && !got; i++) begin
            step();
            if (s_fire) begin
                got = 1'b1;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
                n_checks++;
                if ({s_pc, s_inst} !== {32'h200, 32'h200 ^ PAT} || {s_pc, s_inst} !== e) begin
                    n_errors++;
                    $display("FAIL stall_first: got %h, expected %h", {s_pc, s_inst}, {32'h200, 32'h200 ^ PAT});
                end
            end
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL stall_timeout: got no transfer, expected one");
        end
    endtask

    task automatic test_flush_inflight();
        logic got = 1'b0;
        lat = 3; imem_gnt = 1'b1; id_ready = 1'b1;
        apply_reset(32'h0);
        step();
        step();
        flush = 1'b1; redirect = 32'h100;
        step();
        flush = 1'b0;
        n_checks++;
        if ({s_pcwre, s_req, s_valid} !== 3'b100) begin
            n_errors++;
            $display("FAIL fl_cycle: got pcwre/req/valid=%b, expected 100", {s_pcwre, s_req, s_valid});
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (s_req !== 1'b0) begin
                n_errors++;
                $display("FAIL fl_drop %0d: got req=%b, expected 0", i, s_req);
            end
        end
        step();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h100) begin
            n_errors++;
            $display("FAIL fl_resume: got req=%b addr=%h, expected 1/00000100", s_req, s_addr);
        end
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (s_fire) begin
                got = 1'b1;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                n_checks++;
                if ({s_pc, s_inst} !== {32'h100, 32'h100 ^ PAT}) begin
                    n_errors++;
                    $display("FAIL fl_first: got %h, expected %h", {s_pc, s_inst}, {32'h100, 32'h100 ^ PAT});
                end
            end
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL fl_timeout: got no transfer, expected one");
        end
    endtask

    task automatic test_flush_coincident();
        logic got = 1'b0;
        lat = 2; imem_gnt = 1'b1; id_ready = 1'b1;
        apply_reset(32'h0);
        step();
        step();
        step();
        // head filled, response for pc 4 arriving, two entries unfilled
        flush = 1'b1; redirect = 32'h300;
        step();
        flush = 1'b0;
        n_checks++;
        if ({s_pcwre, s_req, s_valid, imem_rvalid} !== 4'b1001) begin
            n_errors++;
            $display("FAIL fc_cycle: got pcwre/req/valid/rvalid=%b, expected 1001",
                     {s_pcwre, s_req, s_valid, imem_rvalid});
        end
        step();
        n_checks++;
        if (s_req !== 1'b0 || s_valid !== 1'b0 || {s_pc, s_inst} !== 64'h0) begin
            n_errors++;
            $display("FAIL fc_empty: got req=%b valid=%b head=%h, expected 0/0/0", s_req, s_valid, {s_pc, s_inst});
        end
        step();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h300) begin
            n_errors++;
            $display("FAIL fc_resume: got req=%b addr=%h, expected 1/00000300", s_req, s_addr);
        end
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (s_fire) begin
                got = 1'b1;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                n_checks++;
                if ({s_pc, s_inst} !== {32'h300, 32'h300 ^ PAT}) begin
                    n_errors++;
                    $display("FAIL fc_first: got %h, expected %h", {s_pc, s_inst}, {32'h300, 32'h300 ^ PAT});
                end
            end
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL fc_timeout: got no transfer, expected one");
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b0; flush = 1'b0; imem_gnt = 1'b0; id_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; CurPC = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_grant_stall();
        test_flush_inflight();
        test_flush_coincident();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
